// File: rtl/time_counter_if.sv
// Button inputs and time/mode outputs of the clock core.
// slave is the core side, master the driver/observer side.
interface time_counter_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec_o;
  logic [5:0] min_o;
  logic [4:0] hour_o;
  logic [1:0] mode_o;
  logic       tick_o;

  modport master (
    output btn_mode, btn_inc,
    input  sec_o, min_o, hour_o, mode_o, tick_o
  );

  modport slave (
    input  btn_mode, btn_inc,
    output sec_o, min_o, hour_o, mode_o, tick_o
  );
endinterface

// File: rtl/time_counter.sv
// Digital clock core: 1 Hz prescaler, hh:mm:ss chain,
// and a two-button RUN/SET_HOUR/SET_MIN mode machine.
module time_counter #(
  parameter int CLK_HZ = 50_000_000
) (
  input logic           clk,
  input logic           rst,
  time_counter_if.slave bus
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  mode_t         state;
  logic [PW-1:0] pcnt;
  logic [5:0]    sec;
  logic [5:0]    min;
  logic [4:0]    hour;
  logic          tick;
  logic          mode_prev;
  logic          inc_prev;
  logic          mode_edge;
  logic          inc_edge;

  assign mode_edge = bus.btn_mode & ~mode_prev;
  assign inc_edge  = bus.btn_inc  & ~inc_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pcnt      <= '0;
      sec       <= '0;
      min       <= '0;
      hour      <= '0;
      tick      <= 1'b0;
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
    end else begin
      mode_prev <= bus.btn_mode;
      inc_prev  <= bus.btn_inc;
      tick      <= 1'b0;
      unique case (state)
        RUN: begin
          if (pcnt == PMAX) begin
            pcnt <= '0;
            tick <= 1'b1;
            if (sec == 6'd59) begin
              sec <= '0;
              if (min == 6'd59) begin
                min  <= '0;
                hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
              end else begin
                min <= min + 6'd1;
              end
            end else begin
              sec <= sec + 6'd1;
            end
          end else begin
            pcnt <= pcnt + PW'(1);
          end
          // prescaler parks at 0 for the whole time we are setting
          if (mode_edge) begin
            state <= SET_HOUR;
            pcnt  <= '0;
          end
        end
        SET_HOUR: begin
          pcnt <= '0;
          if (mode_edge) begin
            state <= SET_MIN;
          end else if (inc_edge) begin
            hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
          end
        end
        SET_MIN: begin
          pcnt <= '0;
          if (mode_edge) begin
            state <= RUN;
            sec   <= '0;
          end else if (inc_edge) begin
            min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
          end
        end
        default: begin
          state <= RUN;
          pcnt  <= '0;
        end
      endcase
    end
  end

  assign bus.sec_o  = sec;
  assign bus.min_o  = min;
  assign bus.hour_o = hour;
  assign bus.mode_o = state;
  assign bus.tick_o = tick;

endmodule
